// File: rtl/pdm_pkg.sv
// Shared types and constants for the PDM microphone capture controller.
// Holds the session state encoding and the M_CLK half-period helper.
package pdm_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAKE,
        CAPTURE,
        STOPPING,
        DRAIN
    } state_e;

    localparam int DEF_INPUT_FREQ  = 100_000_000;
    localparam int DEF_OUTPUT_FREQ = 2_400_000;
    localparam int DEF_WORD_W      = 16;
    localparam int DEF_WAKE_CYCLES = 2400;

    // Number of clk cycles M_CLK spends in each phase (integer division).
    function automatic int calc_half(input int in_freq, input int out_freq);
        return (in_freq / out_freq) / 2;
    endfunction

endpackage

// File: rtl/pdm_capture_ctrl_if.sv
// Valid/ready word stream carrying raw PDM words to the decimation filter.
interface pdm_capture_ctrl_if #(
    parameter int WORD_W = pdm_pkg::DEF_WORD_W
) ();
    logic [WORD_W-1:0] word_data;
    logic              word_valid;
    logic              word_ready;

    modport master (output word_data, output word_valid, input word_ready);
    modport slave  (input word_data, input word_valid, output word_ready);
endinterface

// File: rtl/pdm_clk_div.sv
// Enable-gated M_CLK divider with a registered rise strobe and a flag that
// marks the low-phase wrap point where the clock may be halted cleanly.
module pdm_clk_div #(
    parameter int HALF = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic m_clk,
    output logic rise,
    output logic low_wrap
);
    localparam int CNT_W = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HALF - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mclk_q, mclk_d;
    logic             rise_q, rise_d;

    always_comb begin
        cnt_d  = cnt_q;
        mclk_d = mclk_q;
        if (!en) begin
            cnt_d  = '0;
            mclk_d = 1'b0;
        end else if (cnt_q == CNT_MAX) begin
            cnt_d  = '0;
            mclk_d = ~mclk_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
        // Strobe coincides with the first clk cycle of the M_CLK high phase.
        rise_d = ~mclk_q & mclk_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            mclk_q <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            mclk_q <= mclk_d;
            rise_q <= rise_d;
        end
    end

    assign m_clk    = mclk_q;
    assign rise     = rise_q;
    assign low_wrap = ~mclk_q & (cnt_q == '0);

endmodule

// File: rtl/pdm_capture_ctrl.sv
// PDM capture session controller: start/stop sequencing, mic wake-up delay,
// M_CLK generation and MSB-first deserialisation into valid/ready words.
module pdm_capture_ctrl
    import pdm_pkg::*;
#(
    parameter int INPUT_FREQ  = DEF_INPUT_FREQ,
    parameter int OUTPUT_FREQ = DEF_OUTPUT_FREQ,
    parameter int WORD_W      = DEF_WORD_W,
    parameter int WAKE_CYCLES = DEF_WAKE_CYCLES
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      stop,
    input  logic                      M_DATA,
    output logic                      M_CLK,
    output logic                      M_LRSEL,
    output logic                      busy,
    output logic                      overflow,
    pdm_capture_ctrl_if.master        wbus
);
    localparam int HALF   = calc_half(INPUT_FREQ, OUTPUT_FREQ);
    localparam int WAKE_W = $clog2(WAKE_CYCLES + 1);
    localparam int BIT_W  = $clog2(WORD_W);

    state_e              state_q, state_d;
    logic [WAKE_W-1:0]   wake_cnt_q, wake_cnt_d;
    logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [WORD_W-1:0]   shift_q, shift_d;
    logic [WORD_W-1:0]   word_data_q, word_data_d;
    logic                word_valid_q, word_valid_d;
    logic                overflow_q, overflow_d;
    logic                busy_q, busy_d;

    logic                div_en, rise, low_wrap;
    logic                complete, accept;
    logic [WORD_W-1:0]   shifted;

    pdm_clk_div #(.HALF(HALF)) u_clk_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (div_en),
        .m_clk    (M_CLK),
        .rise     (rise),
        .low_wrap (low_wrap)
    );

    // While stopping, the divider halts at the first low-phase wrap so M_CLK rests at 0.
    assign div_en  = (state_q == WAKE) || (state_q == CAPTURE) ||
                     ((state_q == STOPPING) && !low_wrap);
    assign shifted = {shift_q[WORD_W-2:0], M_DATA};
    assign accept  = word_valid_q && wbus.word_ready;

    always_comb begin
        state_d      = state_q;
        wake_cnt_d   = wake_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        word_data_d  = word_data_q;
        word_valid_d = word_valid_q;
        overflow_d   = overflow_q;
        complete     = 1'b0;

        case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    state_d    = WAKE;
                    overflow_d = 1'b0;
                    wake_cnt_d = '0;
                    bit_cnt_d  = '0;
                    shift_d    = '0;
                end
            end
            WAKE: begin
                if (stop) begin
                    state_d = STOPPING;
                end else if (rise) begin
                    wake_cnt_d = wake_cnt_q + 1'b1;
                    if (wake_cnt_q == WAKE_W'(WAKE_CYCLES - 1)) begin
                        state_d = CAPTURE;
                    end
                end
            end
            CAPTURE: begin
                if (stop) begin
                    state_d = STOPPING;
                end else if (rise) begin
                    shift_d = shifted;
                    if (bit_cnt_q == BIT_W'(WORD_W - 1)) begin
                        bit_cnt_d = '0;
                        complete  = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            STOPPING: begin
                if (low_wrap) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!word_valid_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            word_valid_d = 1'b0;
        end
        // A slot freed by a same-cycle acceptance may take the new word.
        if (complete) begin
            if (!word_valid_q || accept) begin
                word_data_d  = shifted;
                word_valid_d = 1'b1;
            end else begin
                overflow_d = 1'b1;
            end
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            wake_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            word_data_q  <= '0;
            word_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            wake_cnt_q   <= wake_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            word_data_q  <= word_data_d;
            word_valid_q <= word_valid_d;
            overflow_q   <= overflow_d;
            busy_q       <= busy_d;
        end
    end

    assign wbus.word_data  = word_data_q;
    assign wbus.word_valid = word_valid_q;
    assign busy            = busy_q;
    assign overflow        = overflow_q;
    assign M_LRSEL         = 1'b0;

endmodule

// File: tb/tb_pdm_capture_ctrl.sv
// Directed bench for pdm_capture_ctrl: 8-bit words, 4-edge wake-up, default clocks.
module tb_pdm_capture_ctrl;
    localparam int WORD_W = 8;
    localparam int WAKE   = 4;
    localparam logic [7:0] WORDS [4] = '{8'hB2, 8'h5C, 8'h3E, 8'hA7};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic stop = 1'b0;
    logic m_data;
    logic m_clk, m_lrsel, busy, overflow;

    int n_tests = 0;
    int n_fail  = 0;
    int rise_cnt = 0;
    int rise_base = 0;
    int cyc = 0;
    int prev_rise_cyc = 0;
    int last_rise_cyc = 0;
    int n_acc = 0;

    pdm_capture_ctrl_if #(.WORD_W(WORD_W)) wbus ();

    pdm_capture_ctrl #(
        .INPUT_FREQ  (100_000_000),
        .OUTPUT_FREQ (2_400_000),
        .WORD_W      (WORD_W),
        .WAKE_CYCLES (WAKE)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .stop     (stop),
        .M_DATA   (m_data),
        .M_CLK    (m_clk),
        .M_LRSEL  (m_lrsel),
        .busy     (busy),
        .overflow (overflow),
        .wbus     (wbus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) cyc++;

    always @(posedge m_clk) begin
        rise_cnt++;
        prev_rise_cyc = last_rise_cyc;
        last_rise_cyc = cyc;
    end

    always @(posedge clk) begin
        if (wbus.word_valid && wbus.word_ready) n_acc++;
    end

    // Capture bit i (0-based, after wake-up) is bit 7-(i%8) of the (i/8)-th table word.
    function automatic logic stream_bit(input int i);
        logic [7:0] w;
        w = WORDS[(i / 8) % 4];
        return w[7 - (i % 8)];
    endfunction

    always_comb begin
        m_data = 1'b0;
        if (rise_cnt - rise_base > WAKE) m_data = stream_bit(rise_cnt - rise_base - WAKE - 1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end else begin
            $display("[TB] pass %s = 0x%0h", tag, got);
        end
    endtask

    task automatic do_start();
        @(negedge clk);
        rise_base = rise_cnt;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic do_stop();
        @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int i;
        i = 0;
        @(negedge clk);
        while (!wbus.word_valid && i < 3000) begin
            @(negedge clk);
            i++;
        end
        check_eq({tag, "_valid_seen"}, 32'(wbus.word_valid), 32'd1);
    endtask

    task automatic wait_rises(input int n);
        int i;
        i = 0;
        while ((rise_cnt - rise_base) < n && i < 3000) begin
            @(negedge clk);
            i++;
        end
        check_eq("rise_reached", 32'((rise_cnt - rise_base) >= n), 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        int i;
        i = 0;
        while (busy && i < 300) begin
            @(negedge clk);
            i++;
        end
        check_eq({tag, "_busy_low"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int acc0;
        int r0;
        wbus.word_ready = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        check_eq("rst_mclk", 32'(m_clk), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("rst_valid", 32'(wbus.word_valid), 32'd0);
        check_eq("rst_overflow", 32'(overflow), 32'd0);
        check_eq("rst_data", 32'(wbus.word_data), 32'd0);
        check_eq("lrsel", 32'(m_lrsel), 32'd0);

        // Basic capture with word_ready held high
        do_start();
        check_eq("basic_busy", 32'(busy), 32'd1);
        wait_valid("basic_w1");
        check_eq("basic_w1_rises", 32'(rise_cnt - rise_base), 32'd12);
        check_eq("basic_w1_data", 32'(wbus.word_data), 32'hB2);
        check_eq("mclk_period", 32'(last_rise_cyc - prev_rise_cyc), 32'd40);
        wait_valid("basic_w2");
        check_eq("basic_w2_data", 32'(wbus.word_data), 32'h5C);
        do_stop();
        wait_idle("basic");
        check_eq("basic_overflow", 32'(overflow), 32'd0);

        // Backpressure: second word dropped, first held
        wbus.word_ready = 1'b0;
        do_start();
        wait_valid("bp_w1");
        check_eq("bp_w1_data", 32'(wbus.word_data), 32'hB2);
        wait_rises(20);
        repeat (2) @(negedge clk);
        check_eq("bp_overflow", 32'(overflow), 32'd1);
        check_eq("bp_held_valid", 32'(wbus.word_valid), 32'd1);
        check_eq("bp_held_data", 32'(wbus.word_data), 32'hB2);
        wbus.word_ready = 1'b1;
        @(negedge clk);
        check_eq("bp_accept_clears", 32'(wbus.word_valid), 32'd0);
        wait_valid("bp_w3");
        check_eq("bp_w3_data", 32'(wbus.word_data), 32'h3E);
        do_stop();
        wait_idle("bp");
        check_eq("bp_overflow_sticky", 32'(overflow), 32'd1);

        // New start clears overflow; then accept coincides with completion
        wbus.word_ready = 1'b0;
        do_start();
        check_eq("restart_overflow", 32'(overflow), 32'd0);
        wait_valid("sim_w1");
        check_eq("sim_w1_data", 32'(wbus.word_data), 32'hB2);
        wait_rises(20);
        wbus.word_ready = 1'b1;
        @(negedge clk);
        wbus.word_ready = 1'b0;
        check_eq("sim_valid", 32'(wbus.word_valid), 32'd1);
        check_eq("sim_data", 32'(wbus.word_data), 32'h5C);
        check_eq("sim_overflow", 32'(overflow), 32'd0);
        wbus.word_ready = 1'b1;
        do_stop();
        wait_idle("sim");

        // Stop after three captured bits
        acc0 = n_acc;
        do_start();
        wait_rises(WAKE + 3);
        @(negedge clk);
        do_stop();
        check_eq("stop_mclk_high", 32'(m_clk), 32'd1);
        wait_idle("stop");
        check_eq("stop_mclk_low", 32'(m_clk), 32'd0);
        check_eq("stop_no_word", 32'(n_acc - acc0), 32'd0);
        r0 = rise_cnt;
        repeat (60) @(negedge clk);
        check_eq("stop_halted", 32'(rise_cnt - r0), 32'd0);
        check_eq("stop_mclk_rest", 32'(m_clk), 32'd0);

        // start and stop together in IDLE
        @(negedge clk);
        start = 1'b1;
        stop = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stop = 1'b0;
        check_eq("startstop_busy", 32'(busy), 32'd0);
        repeat (30) @(negedge clk);
        check_eq("startstop_mclk", 32'(m_clk), 32'd0);
        check_eq("startstop_busy_late", 32'(busy), 32'd0);

        // Asynchronous reset mid-capture
        wbus.word_ready = 1'b0;
        do_start();
        wait_valid("ar_w1");
        wait_rises(13);
        check_eq("ar_mclk_before", 32'(m_clk), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("ar_mclk", 32'(m_clk), 32'd0);
        check_eq("ar_valid", 32'(wbus.word_valid), 32'd0);
        check_eq("ar_busy", 32'(busy), 32'd0);
        check_eq("ar_data", 32'(wbus.word_data), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wbus.word_ready = 1'b1;
        do_start();
        wait_valid("ar_restart");
        check_eq("ar_restart_rises", 32'(rise_cnt - rise_base), 32'd12);
        check_eq("ar_restart_data", 32'(wbus.word_data), 32'hB2);
        do_stop();
        wait_idle("ar_end");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
